// File: rtl/mul_div.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle over 32 cycles, with a one-cycle path for divide special cases.
module mul_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    state_t      state_q;
    logic [2:0]  op_q;
    logic [4:0]  cnt_q;
    logic [31:0] opb_q;
    logic [63:0] acc_q;
    logic        neg_q;
    logic        fast_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] res_q;

    logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic        div_zero_s, ovf_s, fast_s, neg_d;
    logic [31:0] a_mag_s, b_mag_s, fast_res_s, opb_d;
    logic [63:0] acc_init_d;

    // Operand decode at accept: magnitudes, result sign and special cases.
    always_comb begin
        a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg_s    = a_signed_s & a[31];
        b_neg_s    = b_signed_s & b[31];
        a_mag_s    = magnitude(a, a_neg_s);
        b_mag_s    = magnitude(b, b_neg_s);
        div_zero_s = op[2] && (b == 32'd0);
        ovf_s      = ((op == OP_DIV) || (op == OP_REM)) &&
                     (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        fast_s     = div_zero_s || ovf_s;
        // Remainder follows the dividend sign; everything else uses the sign product.
        neg_d      = (op[2] && op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
        if (div_zero_s) begin
            fast_res_s = op[1] ? a : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            fast_res_s = op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else begin
            fast_res_s = 32'h0000_0000;
        end
        if (fast_s) begin
            opb_d      = 32'd0;
            acc_init_d = {32'd0, fast_res_s};
        end else if (op[2]) begin
            opb_d      = b_mag_s;
            acc_init_d = {32'd0, a_mag_s};
        end else begin
            opb_d      = a_mag_s;
            acc_init_d = {32'd0, b_mag_s};
        end
    end

    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic        div_qbit_s;
    logic [63:0] acc_d;

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        div_shift_s = {acc_q[63:32], acc_q[31]};
        div_diff_s  = div_shift_s - {1'b0, opb_q};
        div_qbit_s  = ~div_diff_s[32];
        if (op_q[2]) begin
            acc_d = {(div_qbit_s ? div_diff_s[31:0] : div_shift_s[31:0]),
                     acc_q[30:0], div_qbit_s};
        end else begin
            acc_d = {mul_sum_s, acc_q[31:1]};
        end
    end

    logic [63:0] prod_s;
    logic [31:0] fin_res_d;

    // Sign correction and result selection for the FIN state.
    always_comb begin
        prod_s = neg_q ? (64'd0 - acc_q) : acc_q;
        case (op_q)
            OP_MUL:                      fin_res_d = prod_s[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res_d = prod_s[63:32];
            OP_DIV, OP_DIVU:             fin_res_d = magnitude(acc_q[31:0], neg_q);
            OP_REM, OP_REMU:             fin_res_d = magnitude(acc_q[63:32], neg_q);
            default:                     fin_res_d = 32'h0000_0000;
        endcase
        if (fast_q) begin
            fin_res_d = acc_q[31:0];
        end else begin
            fin_res_d = fin_res_d;
        end
    end

    // Control FSM with registered busy/done/res.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            cnt_q   <= 5'd0;
            opb_q   <= 32'd0;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
            fast_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        cnt_q   <= 5'd0;
                        opb_q   <= opb_d;
                        acc_q   <= acc_init_d;
                        neg_q   <= neg_d;
                        fast_q  <= fast_s;
                        busy_q  <= 1'b1;
                        state_q <= fast_s ? S_FIN : S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIN;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_FIN: begin
                    res_q   <= fin_res_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: doc/mul_div.md
# mul_div

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute stage. It consumes the same register-file/forwarded operands as the ALU, computes the M-extension result over multiple cycles and hands it to the writeback mux. Its `busy` output stalls the pipeline front end while an operation is in flight.

## Interface

Parameters:
- none; operand width is fixed at 32 bits (`word` from `decoder_pkg`).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  32  rs1 operand (dividend / multiplicand); sampled with `start`.
- `b`  in  32  rs2 operand (divisor / multiplier); sampled with `start`.
- `busy`  out  1  high from the accepting edge until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `res` valid.
- `res`  out  32  result; holds its value until the next completion or reset.

## Operation

- States: IDLE, RUN, FIN.
- IDLE + `start`:
  - Latch `op`, the operand magnitudes and the result-sign flags.
  - Clear the 5-bit counter.
  - Go to FIN if the op is a special case, otherwise go to RUN.
- Signedness of operands:
  - Both operands signed: MULH, DIV, REM.
  - `a` signed, `b` unsigned: MULHSU.
  - Both operands unsigned: MUL, MULHU, DIVU, REMU.
  - Magnitude of a negative signed operand = two's complement, so 0x8000_0000 becomes 2^31.
- RUN performs one iteration per cycle, 32 iterations, counter 0..31. The counter wraps 31→0 and the state goes to FIN on the same edge.
  - Multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - Divide datapath: 33-bit partial-remainder subtract; the quotient bit is 1 when the difference is non-negative.
- FIN registers the sign-corrected result into `res`, pulses `done`, returns to IDLE.
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits. The 64-bit product is negated before selection when the result sign is negative.
  - DIV/DIVU: quotient, negated if the operand signs differ (signed ops only).
  - REM/REMU: remainder, taking the sign of the dividend (signed ops only).
- Special cases (fast path, skip RUN, result precomputed at accept):
  - Divide by zero (b == 0):
    - DIV/DIVU → 0xFFFF_FFFF.
    - REM/REMU → `a`.
  - Signed overflow (a == 0x8000_0000, b == 0xFFFF_FFFF):
    - DIV → 0x8000_0000.
    - REM → 0.
  - Multiplies never take the fast path.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- `start` in the cycle `done` is high (state IDLE) is accepted normally: back-to-back issue.
- Changes on `a`/`b`/`op` after the accepting edge have no effect.

## Timing

- Reset values:
  - state IDLE, counter 0.
  - `busy` = 0, `done` = 0, `res` = 0x0000_0000.
  - Internal accumulators cleared.
- Edge numbering: E0 is the edge sampling `start`.
- Normal op:
  - RUN iterations at E1..E32; FIN at E33.
  - `busy` is high in the cycles after E0 through E32.
  - `done` is high for the single cycle after E33.
  - Latency is 33 cycles, start to `done`.
- Fast path:
  - FIN at E1, `busy` high for one cycle, `done` after E1.
  - Latency is 1 cycle.
- `busy` and `done` are never high in the same cycle.
- Reset mid-RUN or mid-FIN aborts immediately:
  - No `done` pulse; `res` is cleared.
  - The first `start` after reset release is accepted.
- Throughput: at most one op per 34 cycles (normal path) or per 2 cycles (fast path).

## Test plan

- MUL a=7, b=6 → `res` = 0x0000_002A, `done` 33 cycles after start; `busy` high for exactly 33 cycles.
- MULH a=0xFFFF_FFFF (−1), b=0xFFFF_FFFF → 0x0000_0000. MULHU with the same operands → 0xFFFF_FFFE. MULHSU a=−1, b=2 → 0xFFFF_FFFF.
- Signed divide, a=−7, b=2:
  - DIV → 0xFFFF_FFFD (−3).
  - REM → 0xFFFF_FFFF (−1).
  - DIVU a=100, b=7 → 14; REMU → 2.
- Special cases, each with `done` one cycle after start and RUN skipped:
  - DIV a=5, b=0 → 0xFFFF_FFFF; REM a=5, b=0 → 5.
  - DIV a=0x8000_0000, b=−1 → 0x8000_0000; REM with the same operands → 0.
- Back-to-back and ignored start:
  - Pulse `start` again during RUN with different operands → ignored; first result correct.
  - Assert `start` in the `done` cycle → second op accepted; correct result 33 cycles later.
- Assert `reset` at RUN counter 15 → `busy`/`done`/`res` = 0 immediately, no `done` pulse. A subsequent MUL 3×3 returns 9.
